// File: rtl/plru_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : plru_update_unit
//  Purpose  : Tree pseudo-LRU controller for a 4-way set-associative cache.
//             It sits in front of a dual-port LRU array. For each lookup it
//             reads the 3 PLRU bits of the set and returns the victim way.
//             It then writes back the bits with the touched way marked
//             most-recently-used. Throughput is one lookup per cycle, with
//             valid/ready handshakes on both sides.
//  Ports    :
//    clk, rst                      clock, synchronous active-high reset
//    req_valid/req_ready           lookup request handshake
//    req_set, req_hit, req_way     lookup set, hit flag, hit way
//    resp_valid/resp_ready         victim response handshake
//    resp_set, resp_victim         response set and victim way
//    lru_csb0/web0/addr0/din0      array port0 control (read only)
//    lru_dout0                     array port0 read data
//    lru_csb1/web1/addr1/din1      array port1 control (write only)
//    lru_dout1                     array port1 read data (not used)
//  Revision : 1.0  initial release
// ============================================================================
module plru_update_unit #(
   parameter int S_INDEX = 4
) (
   input  logic               clk,
   input  logic               rst,
   // request side
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [S_INDEX-1:0] req_set,
   input  logic               req_hit,
   input  logic [1:0]         req_way,
   // response side
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [S_INDEX-1:0] resp_set,
   output logic [1:0]         resp_victim,
   // LRU array port0 (read)
   output logic               lru_csb0,
   output logic               lru_web0,
   output logic [S_INDEX-1:0] lru_addr0,
   output logic [2:0]         lru_din0,
   input  logic [2:0]         lru_dout0,
   // LRU array port1 (write)
   output logic               lru_csb1,
   output logic               lru_web1,
   output logic [S_INDEX-1:0] lru_addr1,
   output logic [2:0]         lru_din1,
   input  logic [2:0]         lru_dout1
);

   // ------------------------------------------------------------------------
   // PLRU tree helpers. b[0] is the root, b[1] the ways 0/1 pair and b[2]
   // the ways 2/3 pair. A set bit points the victim search to the right
   // child.
   // ------------------------------------------------------------------------
   function automatic logic [1:0] plru_victim(input logic [2:0] b);
      logic [1:0] v;
      if (!b[0]) v = b[1] ? 2'd1 : 2'd0;
      else       v = b[2] ? 2'd3 : 2'd2;
      return v;
   endfunction

   // Marking a way MRU points every node on its path away from that way.
   function automatic logic [2:0] plru_update(input logic [2:0] b,
                                              input logic [1:0] way);
      logic [2:0] n;
      n = b;
      case (way)
         2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
         2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
         2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
         default: begin n[0] = 1'b0; n[2] = 1'b0; end
      endcase
      return n;
   endfunction

   // ------------------------------------------------------------------------
   // Stage S1. This stage holds the lookup whose array read is in flight.
   // ------------------------------------------------------------------------
   logic               s1_valid;
   logic [S_INDEX-1:0] s1_set;
   logic               s1_hit;
   logic [1:0]         s1_way;

   logic               accept;
   logic               fire;
   logic [1:0]         victim;
   logic [1:0]         touched;
   logic [2:0]         new_bits;

   // Reset gates the handshakes combinationally. As a result, a lookup still
   // sitting in S1 when rst rises can neither respond nor write back.
   assign req_ready = !rst && (!s1_valid || resp_ready);
   assign accept    = req_valid && req_ready;
   assign fire      = !rst && s1_valid && resp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_set   <= '0;
         s1_hit   <= 1'b0;
         s1_way   <= 2'd0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_set   <= req_set;
         s1_hit   <= req_hit;
         s1_way   <= req_way;
      end else if (fire) begin
         s1_valid <= 1'b0;
      end
      // Otherwise the stage is stalled and all S1 registers hold.
   end

   // ------------------------------------------------------------------------
   // Port0 read. While no request is accepted, csb0 stays high, so the array
   // holds dout0 stable for a stalled response.
   // ------------------------------------------------------------------------
   assign lru_csb0  = !accept;
   assign lru_web0  = 1'b1;
   assign lru_addr0 = accept ? req_set : '0;
   assign lru_din0  = 3'b000;

   // ------------------------------------------------------------------------
   // Response and writeback. A same-set lookup immediately behind this one
   // reads the new bits through the array's write-to-read bypass, so no
   // hazard logic is needed here.
   // ------------------------------------------------------------------------
   assign victim   = plru_victim(lru_dout0);
   assign touched  = s1_hit ? s1_way : victim;
   assign new_bits = plru_update(lru_dout0, touched);

   assign resp_valid  = s1_valid && !rst;
   assign resp_set    = s1_set;
   assign resp_victim = victim;

   assign lru_csb1  = !fire;
   assign lru_web1  = !fire;
   assign lru_addr1 = fire ? s1_set   : '0;
   assign lru_din1  = fire ? new_bits : 3'b000;

   // Port1 is write-only from this block's point of view.
   logic unused_dout1;
   assign unused_dout1 = ^lru_dout1;

endmodule
`default_nettype wire

// File: tb/tb_plru_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plru_update_unit
//  Purpose  : Self-checking bench for plru_update_unit with a behavioural
//             dual-port LRU array. The array model has a synchronous read,
//             holds its output while deselected, bypasses a same-cycle
//             write to the read port, and clears on reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plru_update_unit;

   localparam int S_INDEX = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid, req_ready, req_hit;
   logic [S_INDEX-1:0] req_set;
   logic [1:0]         req_way;
   logic               resp_valid, resp_ready;
   logic [S_INDEX-1:0] resp_set;
   logic [1:0]         resp_victim;
   logic               lru_csb0, lru_web0, lru_csb1, lru_web1;
   logic [S_INDEX-1:0] lru_addr0, lru_addr1;
   logic [2:0]         lru_din0, lru_dout0, lru_din1, lru_dout1;

   int errors = 0;
   int checks = 0;
   int wr_count = 0;

   always #5 clk = ~clk;

   plru_update_unit #(.S_INDEX(S_INDEX)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
      .req_hit(req_hit), .req_way(req_way),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_set(resp_set), .resp_victim(resp_victim),
      .lru_csb0(lru_csb0), .lru_web0(lru_web0), .lru_addr0(lru_addr0),
      .lru_din0(lru_din0), .lru_dout0(lru_dout0),
      .lru_csb1(lru_csb1), .lru_web1(lru_web1), .lru_addr1(lru_addr1),
      .lru_din1(lru_din1), .lru_dout1(lru_dout1)
   );

   // Behavioural LRU array.
   logic [2:0] mem [2**S_INDEX];
   assign lru_dout1 = 3'b000;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 2**S_INDEX; k++) mem[k] <= 3'b000;
         lru_dout0 <= 3'b000;
      end else begin
         if (!lru_csb0)
            lru_dout0 <= (!lru_csb1 && !lru_web1 && lru_addr1 == lru_addr0)
                         ? lru_din1 : mem[lru_addr0];
         if (!lru_csb1 && !lru_web1) mem[lru_addr1] <= lru_din1;
      end
   end

   // Count every port1 write the DUT issues, including during reset.
   always @(posedge clk)
      if (!lru_csb1 && !lru_web1) wr_count <= wr_count + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [S_INDEX-1:0] set;
      logic               hit;
      logic [1:0]         way;
      logic [1:0]         victim;
      logic [2:0]         din;
   } vec_t;

   vec_t vecs [10];

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      req_set = '0; req_hit = 1'b0; req_way = 2'd0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst resp_valid", resp_valid, 0);
      check("rst req_ready",  req_ready,  1);
      check("rst csb0",       lru_csb0,   1);
      check("rst csb1",       lru_csb1,   1);
      check("rst web1",       lru_web1,   1);
      check("rst web0",       lru_web0,   1);
      check("rst addr1",      lru_addr1,  0);
      check("rst din1",       lru_din1,   0);
   endtask

   // Streams vectors first..last back-to-back with resp_ready held high.
   task automatic run_group(input int first, input int last);
      do_reset();
      for (int i = first; i <= last + 1; i++) begin
         @(negedge clk);
         if (i <= last) begin
            req_valid = 1'b1; req_set = vecs[i].set;
            req_hit = vecs[i].hit; req_way = vecs[i].way;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (i > first) begin
            check($sformatf("v%0d resp_valid", i-1), resp_valid, 1);
            check($sformatf("v%0d resp_set", i-1), resp_set, vecs[i-1].set);
            check($sformatf("v%0d victim", i-1), resp_victim, vecs[i-1].victim);
            check($sformatf("v%0d csb1", i-1), lru_csb1, 0);
            check($sformatf("v%0d addr1", i-1), lru_addr1, vecs[i-1].set);
            check($sformatf("v%0d din1", i-1), lru_din1, vecs[i-1].din);
         end
         if (i <= last) begin
            check($sformatf("v%0d req_ready", i), req_ready, 1);
            check($sformatf("v%0d csb0", i), lru_csb0, 0);
            check($sformatf("v%0d addr0", i), lru_addr0, vecs[i].set);
         end
      end
      @(negedge clk);
      #1;
      check("drain resp_valid", resp_valid, 0);
      check("drain csb1", lru_csb1, 1);
   endtask

   initial begin
      int base;
      rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
      req_set = '0; req_hit = 1'b0; req_way = 2'd0;

      //            set hit way victim din
      vecs[0] = '{4'd5, 1'b0, 2'd0, 2'd0, 3'b011};  // single miss
      vecs[1] = '{4'd5, 1'b0, 2'd0, 2'd0, 3'b011};  // four misses, same set
      vecs[2] = '{4'd5, 1'b0, 2'd0, 2'd2, 3'b110};
      vecs[3] = '{4'd5, 1'b0, 2'd0, 2'd1, 3'b101};
      vecs[4] = '{4'd5, 1'b0, 2'd0, 2'd3, 3'b000};
      vecs[5] = '{4'd3, 1'b1, 2'd2, 2'd0, 3'b100};  // hit way 2
      vecs[6] = '{4'd3, 1'b0, 2'd0, 2'd0, 3'b111};  // then miss
      vecs[7] = '{4'd1, 1'b0, 2'd0, 2'd0, 3'b011};  // interleaved sets
      vecs[8] = '{4'd2, 1'b0, 2'd0, 2'd0, 3'b011};
      vecs[9] = '{4'd1, 1'b0, 2'd0, 2'd2, 3'b110};

      run_group(0, 0);
      run_group(1, 4);
      run_group(5, 6);
      run_group(7, 9);

      // Stall: the response waits three cycles with a second request queued.
      do_reset();
      @(negedge clk);
      req_valid = 1'b1; req_set = 4'd7; req_hit = 1'b0; resp_ready = 1'b0;
      #1;
      check("stall accept csb0", lru_csb0, 0);
      @(negedge clk);
      #1;
      base = wr_count;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         check($sformatf("stall%0d resp_valid", k), resp_valid, 1);
         check($sformatf("stall%0d resp_set", k), resp_set, 7);
         check($sformatf("stall%0d victim", k), resp_victim, 0);
         check($sformatf("stall%0d req_ready", k), req_ready, 0);
         check($sformatf("stall%0d csb0", k), lru_csb0, 1);
         check($sformatf("stall%0d csb1", k), lru_csb1, 1);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      #1;
      check("stall victim held", resp_victim, 0);
      check("release csb1", lru_csb1, 0);
      check("release web1", lru_web1, 0);
      check("release addr1", lru_addr1, 7);
      check("release din1", lru_din1, 3'b011);
      check("release req_ready", req_ready, 1);
      check("release csb0", lru_csb0, 0);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("bypass victim", resp_victim, 2);
      check("bypass din1", lru_din1, 3'b110);
      @(negedge clk);
      #1;
      check("stall writes", wr_count - base, 2);
      check("stall drain", resp_valid, 0);

      // Reset while a lookup sits in S1.
      do_reset();
      @(negedge clk);
      req_valid = 1'b1; req_set = 4'd9; req_hit = 1'b0; resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; rst = 1'b1;
      #1;
      base = wr_count;
      check("midrst csb1", lru_csb1, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst resp_valid", resp_valid, 0);
      check("midrst req_ready", req_ready, 1);
      check("midrst no write", wr_count - base, 0);
      req_valid = 1'b1; req_set = 4'd9;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("postrst resp_valid", resp_valid, 1);
      check("postrst victim", resp_victim, 0);
      check("postrst din1", lru_din1, 3'b011);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
